// File: rtl/csr_access_unit_pkg.sv
// csr_access_unit_pkg: shared CSR port types, write-function encoding,
// funct3 constants and the access FSM state enum.
package csr_access_unit_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int CSR_ADDR_W_DEF = 12;

    typedef logic [CSR_ADDR_W_DEF-1:0] csr_addr_t;
    typedef logic [4:0]                arch_reg;

    typedef enum logic [1:0] {
        CSR_WF_NONE = 2'b00,
        CSR_WF_RW   = 2'b01,
        CSR_WF_RS   = 2'b10,
        CSR_WF_RC   = 2'b11
    } csr_write_func;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam csr_addr_t CSR_RDCYCLE = 12'hC00;
    localparam csr_addr_t CSR_RDTIME  = 12'hC01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } csr_access_state_t;

    function automatic logic is_bad_funct3(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences CSR instruction read/write strobes into the csr
// block and returns the rd writeback or an illegal-instruction response.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int CSR_ADDR_W = CSR_ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [CSR_ADDR_W-1:0] req_csr_addr,
    input  logic [XLEN-1:0]       req_rs1_value,
    input  logic [4:0]            req_rs1_idx,
    input  logic [4:0]            req_rd_idx,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic                  read_csr,
    output logic                  write_csr,
    output logic [1:0]            write_function,
    output logic [XLEN-1:0]       write_value,
    input  logic [XLEN-1:0]       csr_read_value,
    input  logic                  csr_illegal,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_rd_write,
    output logic [4:0]            resp_rd_idx,
    output logic [XLEN-1:0]       resp_rd_value,
    output logic                  resp_illegal
);
    csr_access_state_t     state_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       operand_q, wvalue_q, rd_value_q;
    csr_write_func         func_q, wfunc_q;
    arch_reg               rd_q;
    logic                  do_read_q, do_write_q, read_q, write_q;
    logic                  valid_q, rd_write_q, illegal_q;

    logic [XLEN-1:0] operand_d;
    logic            do_read_d, do_write_d, bad_d;

    // RS/RC forms skip the write when the rs1 index (or uimm) is zero, regardless of value.
    always_comb begin
        operand_d  = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_value;
        do_read_d  = !(req_funct3[1:0] == 2'b01 && req_rd_idx == 5'd0);
        do_write_d = req_funct3[1:0] == 2'b01 || req_rs1_idx != 5'd0;
        bad_d      = is_bad_funct3(req_funct3);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            operand_q  <= '0;
            wvalue_q   <= '0;
            rd_value_q <= '0;
            func_q     <= CSR_WF_NONE;
            wfunc_q    <= CSR_WF_NONE;
            rd_q       <= '0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            valid_q    <= 1'b0;
            rd_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wfunc_q  <= CSR_WF_NONE;
            wvalue_q <= '0;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    addr_q     <= req_csr_addr;
                    operand_q  <= operand_d;
                    func_q     <= csr_write_func'(req_funct3[1:0]);
                    rd_q       <= req_rd_idx;
                    do_read_q  <= do_read_d;
                    do_write_q <= do_write_d;
                    rd_value_q <= '0;
                    rd_write_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    if (bad_d) begin
                        state_q   <= ST_RESP;
                        valid_q   <= 1'b1;
                        illegal_q <= 1'b1;
                    end else if (do_read_d) begin
                        state_q <= ST_READ;
                        read_q  <= 1'b1;
                    end else begin
                        state_q  <= ST_WRITE;
                        write_q  <= 1'b1;
                        wfunc_q  <= csr_write_func'(req_funct3[1:0]);
                        wvalue_q <= operand_d;
                    end
                end
                ST_READ: begin
                    rd_value_q <= csr_read_value;
                    if (csr_illegal) begin
                        state_q   <= ST_RESP;
                        valid_q   <= 1'b1;
                        illegal_q <= 1'b1;
                    end else if (do_write_q) begin
                        state_q  <= ST_WRITE;
                        write_q  <= 1'b1;
                        wfunc_q  <= func_q;
                        wvalue_q <= operand_q;
                    end else begin
                        state_q    <= ST_RESP;
                        valid_q    <= 1'b1;
                        rd_write_q <= rd_q != 5'd0;
                    end
                end
                ST_WRITE: begin
                    state_q    <= ST_RESP;
                    valid_q    <= 1'b1;
                    illegal_q  <= csr_illegal;
                    rd_write_q <= !csr_illegal && rd_q != 5'd0 && do_read_q;
                end
                ST_RESP: if (resp_ready) begin
                    state_q    <= ST_IDLE;
                    valid_q    <= 1'b0;
                    rd_write_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    rd_value_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = state_q == ST_IDLE;
    assign csr_addr       = addr_q;
    assign read_csr       = read_q;
    assign write_csr      = write_q;
    assign write_function = wfunc_q;
    assign write_value    = wvalue_q;
    assign resp_valid     = valid_q;
    assign resp_rd_write  = rd_write_q;
    assign resp_rd_idx    = rd_q;
    assign resp_rd_value  = rd_value_q;
    assign resp_illegal   = illegal_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed checks of csr_access_unit sequencing,
// latency, response hold and asynchronous reset abort.
module tb_csr_access_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b0;
    logic [11:0] req_csr_addr = 12'h0;
    logic [31:0] req_rs1_value = 32'h0;
    logic [4:0]  req_rs1_idx = 5'd0;
    logic [4:0]  req_rd_idx = 5'd0;
    logic [11:0] csr_addr;
    logic        read_csr;
    logic        write_csr;
    logic [1:0]  write_function;
    logic [31:0] write_value;
    logic [31:0] csr_read_value = 32'h0;
    logic        csr_illegal;
    logic        ill_on_read = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_rd_write;
    logic [4:0]  resp_rd_idx;
    logic [31:0] resp_rd_value;
    logic        resp_illegal;

    int checks = 0;
    int errors = 0;
    int n_rd = 0, n_wr = 0, n_both = 0;
    logic [11:0] seen_raddr = '0, seen_waddr = '0;
    logic [1:0]  seen_wf = '0;
    logic [31:0] seen_wv = '0;

    assign csr_illegal = ill_on_read & read_csr;

    csr_access_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_value(req_rs1_value),
        .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx),
        .csr_addr(csr_addr), .read_csr(read_csr), .write_csr(write_csr),
        .write_function(write_function), .write_value(write_value),
        .csr_read_value(csr_read_value), .csr_illegal(csr_illegal),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd_write(resp_rd_write), .resp_rd_idx(resp_rd_idx),
        .resp_rd_value(resp_rd_value), .resp_illegal(resp_illegal)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (read_csr) begin
            n_rd++;
            seen_raddr = csr_addr;
        end
        if (write_csr) begin
            n_wr++;
            seen_waddr = csr_addr;
            seen_wf = write_function;
            seen_wv = write_value;
        end
        if (read_csr && write_csr) n_both++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int lat, drd, dwr;

    task automatic run(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] v,
                       input logic [4:0] idx, input logic [4:0] rd);
        int b_rd, b_wr;
        b_rd = n_rd;
        b_wr = n_wr;
        req_funct3 = f3;
        req_csr_addr = addr;
        req_rs1_value = v;
        req_rs1_idx = idx;
        req_rd_idx = rd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_rs1_value = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        drd = n_rd - b_rd;
        dwr = n_wr - b_wr;
    endtask

    task automatic finish_resp;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("post_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        tick();
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_strobes", {29'b0, read_csr, write_csr, resp_valid}, 32'd0);
        check("rst_resp", {26'b0, resp_rd_write, resp_rd_idx}, 32'd0);
        check("rst_rd_value", resp_rd_value, 32'd0);
        check("rst_wr", {18'b0, write_function, csr_addr}, 32'd0);
        check("rst_illegal", {31'b0, resp_illegal}, 32'd0);
        reset = 1'b0;
        tick();

        // CSRRS rd=5 rs1=x0 from cycle: read only, index test ignores value
        csr_read_value = 32'h0000_1234;
        run(3'b010, 12'hC00, 32'h0000_FFFF, 5'd0, 5'd5);
        check("t1_lat", lat, 32'd2);
        check("t1_nrd", drd, 32'd1);
        check("t1_nwr", dwr, 32'd0);
        check("t1_raddr", {20'b0, seen_raddr}, 32'h0C00);
        check("t1_rd_write", {31'b0, resp_rd_write}, 32'd1);
        check("t1_rd_idx", {27'b0, resp_rd_idx}, 32'd5);
        check("t1_rd_value", resp_rd_value, 32'h0000_1234);
        check("t1_illegal", {31'b0, resp_illegal}, 32'd0);
        finish_resp();

        // CSRRW rd=0: write only
        run(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd9, 5'd0);
        check("t2_lat", lat, 32'd2);
        check("t2_nrd", drd, 32'd0);
        check("t2_nwr", dwr, 32'd1);
        check("t2_wf", {30'b0, seen_wf}, 32'd1);
        check("t2_wv", seen_wv, 32'hDEAD_BEEF);
        check("t2_waddr", {20'b0, seen_waddr}, 32'h0340);
        check("t2_rd_write", {31'b0, resp_rd_write}, 32'd0);
        check("t2_rd_value", resp_rd_value, 32'd0);
        check("t2_illegal", {31'b0, resp_illegal}, 32'd0);
        finish_resp();

        // CSRRW rd=3 on time, illegal in READ: write suppressed
        ill_on_read = 1'b1;
        run(3'b001, 12'hC01, 32'h5555_AAAA, 5'd2, 5'd3);
        ill_on_read = 1'b0;
        check("t3_lat", lat, 32'd2);
        check("t3_nrd", drd, 32'd1);
        check("t3_nwr", dwr, 32'd0);
        check("t3_illegal", {31'b0, resp_illegal}, 32'd1);
        check("t3_rd_write", {31'b0, resp_rd_write}, 32'd0);
        finish_resp();

        // CSRRCI uimm=0x1F rd=7: read then write with zero-extended uimm
        csr_read_value = 32'h0000_00FF;
        run(3'b111, 12'h300, 32'hAAAA_5555, 5'h1F, 5'd7);
        check("t4_lat", lat, 32'd3);
        check("t4_nrd", drd, 32'd1);
        check("t4_nwr", dwr, 32'd1);
        check("t4_wf", {30'b0, seen_wf}, 32'd3);
        check("t4_wv", seen_wv, 32'h0000_001F);
        check("t4_waddr", {20'b0, seen_waddr}, 32'h0300);
        check("t4_rd_write", {31'b0, resp_rd_write}, 32'd1);
        check("t4_rd_idx", {27'b0, resp_rd_idx}, 32'd7);
        check("t4_rd_value", resp_rd_value, 32'h0000_00FF);
        finish_resp();

        // CSRRSI uimm=0 rd=4: read only
        csr_read_value = 32'hCAFE_0001;
        run(3'b110, 12'h305, 32'h0, 5'd0, 5'd4);
        check("t7_lat", lat, 32'd2);
        check("t7_nrd", drd, 32'd1);
        check("t7_nwr", dwr, 32'd0);
        check("t7_rd_value", resp_rd_value, 32'hCAFE_0001);
        finish_resp();

        // funct3=100: immediate illegal response, held while resp_ready low
        run(3'b100, 12'h300, 32'h1, 5'd1, 5'd6);
        check("t5_lat", lat, 32'd1);
        check("t5_nrd", drd, 32'd0);
        check("t5_nwr", dwr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", {31'b0, resp_valid}, 32'd1);
            check("t5_hold_illegal", {31'b0, resp_illegal}, 32'd1);
            check("t5_hold_rd_write", {31'b0, resp_rd_write}, 32'd0);
            check("t5_hold_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        check("t5_hold_strobes", n_rd + n_wr, 32'd6);
        finish_resp();

        // Reset asserted during WRITE
        req_funct3 = 3'b001;
        req_csr_addr = 12'h341;
        req_rs1_value = 32'h1234_5678;
        req_rs1_idx = 5'd1;
        req_rd_idx = 5'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t6_in_write", {31'b0, write_csr}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_write", {31'b0, write_csr}, 32'd0);
        check("t6_rst_out", {29'b0, read_csr, resp_valid, resp_illegal}, 32'd0);
        check("t6_rst_wv", write_value, 32'd0);
        check("t6_rst_req_ready", {31'b0, req_ready}, 32'd1);
        lat = n_rd + n_wr;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("t6_no_strobes", n_rd + n_wr, lat);
        check("t6_idle_ready", {31'b0, req_ready}, 32'd1);
        check("never_both", n_both, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
